car_park_sensor_emulator: RTL

//   Drives the two photo-beam lines (a, b) of the car park gate with the pattern a real car produces.
//   On command it plays an entry sequence (00->10->11->01->00) or an exit sequence (00->01->11->10->00).

---
 rtl/car_park_sensor_emulator_pkg.sv | 36 +++
 rtl/car_park_sensor_emulator_if.sv | 25 ++
 rtl/car_park_dwell_timer.sv | 27 ++
 rtl/car_park_sensor_emulator.sv | 135 +++++++++++++
 4 files changed

// File: rtl/car_park_sensor_emulator_pkg.sv
// Shared beam-pattern, direction and emulator-state definitions for the car park gate.
// Both the sensor emulator and the occupancy decoder use these pattern constants.
package car_park_pkg;

    localparam logic [1:0] AB_CLEAR = 2'b00;
    localparam logic [1:0] AB_A     = 2'b10;
    localparam logic [1:0] AB_BOTH  = 2'b11;
    localparam logic [1:0] AB_B     = 2'b01;

    localparam logic DIR_ENTER = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    typedef enum logic [2:0] {
        EMU_IDLE,
        EMU_P1,
        EMU_P2,
        EMU_P1B,
        EMU_P2B,
        EMU_P3,
        EMU_GAP
    } emu_state_t;

    // Beam pattern a car produces in each phase; P3 mirrors P1 for the given direction.
    function automatic logic [1:0] ab_pattern(input emu_state_t st, input logic dir);
        logic [1:0] pat;
        pat = AB_CLEAR;
        case (st)
            EMU_P1, EMU_P1B: pat = (dir == DIR_ENTER) ? AB_A : AB_B;
            EMU_P2, EMU_P2B: pat = AB_BOTH;
            EMU_P3:          pat = (dir == DIR_ENTER) ? AB_B : AB_A;
            default:         pat = AB_CLEAR;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/car_park_sensor_emulator_if.sv
// Command/beam interface between a sequence requester and the sensor emulator.
// Optional macro CAR_PARK_EMU_BACKOFF_EN adds the backoff request line.
interface car_park_sensor_emulator_if #(
    parameter int DWELL_W = 16
);
    logic               start;
    logic               dir;
    logic [DWELL_W-1:0] dwell;
`ifdef CAR_PARK_EMU_BACKOFF_EN
    logic               backoff;
`endif
    logic               a;
    logic               b;
    logic               busy;
    logic               done;

`ifdef CAR_PARK_EMU_BACKOFF_EN
    modport master (output start, dir, dwell, backoff, input a, b, busy, done);
    modport slave  (input start, dir, dwell, backoff, output a, b, busy, done);
`else
    modport master (output start, dir, dwell, input a, b, busy, done);
    modport slave  (input start, dir, dwell, output a, b, busy, done);
`endif

endinterface

// File: rtl/car_park_dwell_timer.sv
// Per-phase dwell down counter: loads a value, counts down to zero and holds there.
module car_park_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         tick_en,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick_en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/car_park_sensor_emulator.sv
// Plays entry/exit photo-beam sequences on the a/b lines of the car park gate.
// Optional macro CAR_PARK_EMU_BACKOFF_EN adds the hesitating-car (P1 -> P2 -> P1b -> P2b) path.
module car_park_sensor_emulator
    import car_park_pkg::*;
#(
    parameter int DWELL_W = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    car_park_sensor_emulator_if.slave     bus
);

    emu_state_t         state, next_state;
    logic               dir_q, next_dir;
    logic [DWELL_W-1:0] len_m1_q, next_len_m1, len_in_m1;
    logic               load;
    logic [DWELL_W-1:0] load_value;
    logic               expire;
    logic [1:0]         ab_q;
    logic               busy_q;
    logic               done_q;
`ifdef CAR_PARK_EMU_BACKOFF_EN
    logic               backoff_q, next_backoff;
`endif

    // A dwell of zero still gives one-cycle phases.
    assign len_in_m1 = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);

    car_park_dwell_timer #(.W(DWELL_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .load_value (load_value),
        .tick_en    (state != EMU_IDLE),
        .expire     (expire)
    );

    always_comb begin
        next_state  = state;
        next_dir    = dir_q;
        next_len_m1 = len_m1_q;
        load        = 1'b0;
        load_value  = len_m1_q;
`ifdef CAR_PARK_EMU_BACKOFF_EN
        next_backoff = backoff_q;
`endif
        case (state)
            EMU_IDLE: begin
                if (bus.start) begin
                    next_state  = EMU_P1;
                    next_dir    = bus.dir;
                    next_len_m1 = len_in_m1;
                    load        = 1'b1;
                    load_value  = len_in_m1;
`ifdef CAR_PARK_EMU_BACKOFF_EN
                    next_backoff = bus.backoff;
`endif
                end
            end
            EMU_P1: begin
                if (expire) begin
                    next_state = EMU_P2;
                    load       = 1'b1;
                end
            end
            EMU_P2: begin
                if (expire) begin
                    load = 1'b1;
`ifdef CAR_PARK_EMU_BACKOFF_EN
                    next_state = backoff_q ? EMU_P1B : EMU_P3;
`else
                    next_state = EMU_P3;
`endif
                end
            end
`ifdef CAR_PARK_EMU_BACKOFF_EN
            EMU_P1B: begin
                if (expire) begin
                    next_state = EMU_P2B;
                    load       = 1'b1;
                end
            end
            EMU_P2B: begin
                if (expire) begin
                    next_state = EMU_P3;
                    load       = 1'b1;
                end
            end
`endif
            EMU_P3: begin
                if (expire) begin
                    next_state = EMU_GAP;
                    load       = 1'b1;
                end
            end
            EMU_GAP: begin
                if (expire) begin
                    next_state = EMU_IDLE;
                end
            end
            default: next_state = EMU_IDLE;
        endcase
    end

    // Outputs are registered from the next state so a/b and busy move together with the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EMU_IDLE;
            dir_q    <= DIR_ENTER;
            len_m1_q <= '0;
            ab_q     <= AB_CLEAR;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef CAR_PARK_EMU_BACKOFF_EN
            backoff_q <= 1'b0;
`endif
        end else begin
            state    <= next_state;
            dir_q    <= next_dir;
            len_m1_q <= next_len_m1;
            ab_q     <= ab_pattern(next_state, next_dir);
            busy_q   <= (next_state != EMU_IDLE);
            done_q   <= (state == EMU_GAP) && expire;
`ifdef CAR_PARK_EMU_BACKOFF_EN
            backoff_q <= next_backoff;
`endif
        end
    end

    assign bus.a    = ab_q[1];
    assign bus.b    = ab_q[0];
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
